// File: rtl/tetris_pkg.sv
// +-----------------------------------------------------------------------+
// | tetris_pkg : shared state encoding, 3:3:3 colours, default cell size  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package tetris_pkg;
  typedef logic [3:0] state_t;

  localparam state_t S_IDLE      = 4'd0;
  localparam state_t S_CLR_ISSUE = 4'd1;
  localparam state_t S_CLR_WAIT  = 4'd2;
  localparam state_t S_SNAP      = 4'd3;
  localparam state_t S_ER_ISSUE  = 4'd4;
  localparam state_t S_ER_WAIT   = 4'd5;
  localparam state_t S_DR_ISSUE  = 4'd6;
  localparam state_t S_DR_WAIT   = 4'd7;
  localparam state_t S_COMMIT    = 4'd8;

  localparam logic [8:0] COLOR_BLACK   = 9'h000;
  localparam logic [8:0] COLOR_WHITE   = 9'h1FF;
  localparam logic [8:0] COLOR_MAGENTA = 9'h1C7;

  localparam int DEF_CELL_W = 24;
  localparam int DEF_CELL_H = 24;
endpackage

`default_nettype wire

// File: rtl/cell_to_pixel.sv
// +-----------------------------------------------------------------------+
// | cell_to_pixel : board cell (c,r) to top-left pixel, modulo 10/9 bits   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module cell_to_pixel
  import tetris_pkg::*;
#(
  parameter int CELL_W = DEF_CELL_W,
  parameter int CELL_H = DEF_CELL_H,
  parameter int X_ORG  = 0,
  parameter int Y_ORG  = 0
) (
  input  logic [3:0] c_i,
  input  logic [4:0] r_i,
  output logic [9:0] x0_o,
  output logic [8:0] y0_o
);
  assign x0_o = 10'(X_ORG) + 10'(c_i) * 10'(CELL_W);
  assign y0_o = 9'(Y_ORG) + 9'(r_i) * 9'(CELL_H);
endmodule

`default_nettype wire

// File: rtl/piece_redraw_seq.sv
// +-----------------------------------------------------------------------+
// | piece_redraw_seq : sequences board clears and piece erase/draw paints  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module piece_redraw_seq
  import tetris_pkg::*;
#(
  parameter int CELLS          = 4,
  parameter int COLS           = 10,
  parameter int ROWS           = 20,
  parameter int CELL_W         = DEF_CELL_W,
  parameter int CELL_H         = DEF_CELL_H,
  parameter int X_ORG          = 0,
  parameter int Y_ORG          = 0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               redraw_req,
  input  logic               clear_req,
  input  logic [CELLS*4-1:0] cur_x,
  input  logic [CELLS*5-1:0] cur_y,
  input  logic [8:0]         piece_color,
  input  logic [8:0]         bg_color,
  input  logic               paint_busy,
  input  logic               paint_done,
  output logic               paint_start,
  output logic [9:0]         paint_x0,
  output logic [8:0]         paint_y0,
  output logic [8:0]         paint_color,
  output logic               seq_busy,
  output logic               frame_done
);
  localparam int             IW       = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(CELLS - 1);

  state_t               state_q, state_d;
  logic [3:0]           col_q, col_d;
  logic [4:0]           row_q, row_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CELLS*4-1:0]   snap_x_q, snap_x_d, prev_x_q, prev_x_d;
  logic [CELLS*5-1:0]   snap_y_q, snap_y_d, prev_y_q, prev_y_d;
  logic                 prev_valid_q, prev_valid_d;
  logic                 pend_rd_q, pend_rd_d, pend_clr_q, pend_clr_d;
  logic                 boot_q, boot_d, start_q;
  logic [8:0]           color_q, color_d;

  logic [3:0]  w_c, w_prev_c;
  logic [4:0]  w_r, w_prev_r;
  logic [9:0]  w_px;
  logic [8:0]  w_py, w_color_live;
  logic        w_covered, w_fire, w_clr_last, w_idx_last;

  cell_to_pixel #(.CELL_W(CELL_W), .CELL_H(CELL_H), .X_ORG(X_ORG), .Y_ORG(Y_ORG)) u_c2p (
    .c_i (w_c),
    .r_i (w_r),
    .x0_o(w_px),
    .y0_o(w_py)
  );

  // Cell selection plus the "prev cell already covered by new piece" test.
  always_comb begin
    w_prev_c     = prev_x_q[4*idx_q +: 4];
    w_prev_r     = prev_y_q[5*idx_q +: 5];
    w_c          = col_q;
    w_r          = row_q;
    w_color_live = bg_color;
    case (state_q)
      S_ER_ISSUE, S_ER_WAIT: begin
        w_c = w_prev_c;
        w_r = w_prev_r;
      end
      S_DR_ISSUE, S_DR_WAIT: begin
        w_c          = snap_x_q[4*idx_q +: 4];
        w_r          = snap_y_q[5*idx_q +: 5];
        w_color_live = piece_color;
      end
      default: ;
    endcase
    w_covered = 1'b0;
    for (int j = 0; j < CELLS; j++) begin
      if (snap_x_q[4*j +: 4] == w_prev_c && snap_y_q[5*j +: 5] == w_prev_r) w_covered = 1'b1;
    end
  end

  assign w_clr_last = (col_q == 4'(COLS - 1)) && (row_q == 5'(ROWS - 1));
  assign w_idx_last = (idx_q == LAST_IDX);
  assign w_fire     = ((state_q == S_CLR_ISSUE) || (state_q == S_DR_ISSUE) ||
                       ((state_q == S_ER_ISSUE) && !w_covered)) && !paint_busy && !start_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    idx_d        = idx_q;
    snap_x_d     = snap_x_q;
    snap_y_d     = snap_y_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    prev_valid_d = prev_valid_q;
    pend_rd_d    = pend_rd_q;
    pend_clr_d   = pend_clr_q;
    boot_d       = boot_q;
    color_d      = w_fire ? w_color_live : color_q;
    if (state_q != S_IDLE) begin
      if (redraw_req) pend_rd_d = 1'b1;
      if (clear_req)  pend_clr_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (boot_q || pend_clr_q || clear_req) begin
          state_d    = S_CLR_ISSUE;
          boot_d     = 1'b0;
          pend_clr_d = 1'b0;
          col_d      = '0;
          row_d      = '0;
          if (redraw_req) pend_rd_d = 1'b1;
        end else if (pend_rd_q || redraw_req) begin
          state_d   = S_SNAP;
          pend_rd_d = 1'b0;
        end
      end
      S_CLR_ISSUE: if (w_fire) state_d = S_CLR_WAIT;
      S_CLR_WAIT: begin
        if (paint_done) begin
          if (w_clr_last) begin
            state_d      = S_IDLE;
            prev_valid_d = 1'b0;
            pend_rd_d    = redraw_req;  // older redraws have nothing left to erase
          end else begin
            state_d = S_CLR_ISSUE;
            if (col_q == 4'(COLS - 1)) begin
              col_d = '0;
              row_d = row_q + 5'd1;
            end else begin
              col_d = col_q + 4'd1;
            end
          end
        end
      end
      S_SNAP: begin
        snap_x_d = cur_x;
        snap_y_d = cur_y;
        idx_d    = '0;
        state_d  = prev_valid_q ? S_ER_ISSUE : S_DR_ISSUE;
      end
      S_ER_ISSUE: begin
        if (w_covered) begin
          idx_d   = w_idx_last ? '0 : idx_q + IW'(1);
          state_d = w_idx_last ? S_DR_ISSUE : S_ER_ISSUE;
        end else if (w_fire) begin
          state_d = S_ER_WAIT;
        end
      end
      S_ER_WAIT: begin
        if (paint_done) begin
          idx_d   = w_idx_last ? '0 : idx_q + IW'(1);
          state_d = w_idx_last ? S_DR_ISSUE : S_ER_ISSUE;
        end
      end
      S_DR_ISSUE: if (w_fire) state_d = S_DR_WAIT;
      S_DR_WAIT: begin
        if (paint_done) begin
          idx_d   = w_idx_last ? idx_q : idx_q + IW'(1);
          state_d = w_idx_last ? S_COMMIT : S_DR_ISSUE;
        end
      end
      S_COMMIT: begin
        prev_x_d     = snap_x_q;
        prev_y_d     = snap_y_q;
        prev_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      col_q        <= '0;
      row_q        <= '0;
      idx_q        <= '0;
      snap_x_q     <= '0;
      snap_y_q     <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      prev_valid_q <= 1'b0;
      pend_rd_q    <= 1'b0;
      pend_clr_q   <= 1'b0;
      boot_q       <= CLEAR_ON_RESET;
      start_q      <= 1'b0;
      color_q      <= COLOR_BLACK;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      idx_q        <= idx_d;
      snap_x_q     <= snap_x_d;
      snap_y_q     <= snap_y_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      prev_valid_q <= prev_valid_d;
      pend_rd_q    <= pend_rd_d;
      pend_clr_q   <= pend_clr_d;
      boot_q       <= boot_d;
      start_q      <= w_fire;
      color_q      <= color_d;
    end
  end

  // Coordinates come from counters that only move on paint_done, so they stay put while waiting.
  always_comb begin
    paint_start = w_fire;
    seq_busy    = (state_q != S_IDLE);
    frame_done  = ((state_q == S_CLR_WAIT) && paint_done && w_clr_last) || (state_q == S_COMMIT);
    paint_x0    = '0;
    paint_y0    = '0;
    paint_color = COLOR_BLACK;
    case (state_q)
      S_CLR_ISSUE, S_ER_ISSUE, S_DR_ISSUE: begin
        paint_x0    = w_px;
        paint_y0    = w_py;
        paint_color = w_color_live;
      end
      S_CLR_WAIT, S_ER_WAIT, S_DR_WAIT: begin
        paint_x0    = w_px;
        paint_y0    = w_py;
        paint_color = color_q;
      end
      default: ;
    endcase
  end
endmodule

`default_nettype wire
